avl_dsp_arbiter: RTL



---
 rtl/avl_dsp_arb_pkg.sv | 16 +
 rtl/avl_dsp_arbiter_rr.sv | 37 +++
 rtl/avl_dsp_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/avl_dsp_arb_pkg.sv
// Shared types for the DSP register-file arbiter: FSM states, requester id,
// and the read-latency counter width.
package avl_dsp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RD_WAIT,
        ST_RD_RESP
    } arb_state_t;

    typedef logic req_id_t;

    localparam int unsigned CNT_W = $clog2(8);

endpackage

// File: rtl/avl_dsp_arbiter_rr.sv
// Two-input round-robin grant; last_grant only advances when a grant is taken.
module rr_arbiter_2
    import avl_dsp_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output req_id_t    grant
);

    req_id_t last_grant_q, last_grant_d;

    always_comb begin
        if (req == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req[0]) begin
            grant = 1'b0;
        end else begin
            grant = 1'b1;
        end
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = grant;
        end
    end

    // Resetting to 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/avl_dsp_arbiter.sv
// Avalon-MM arbiter sharing the DSP register-file port between the HPS path
// (m0) and the configuration sequencer (m1); one access outstanding at a time.
module avl_dsp_arbiter
    import avl_dsp_arb_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR = 8,
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_BE   = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk_dsp,
    input  logic                  reset_n,
    input  logic                  m0_write,
    input  logic                  m0_read,
    input  logic [WIDTH_ADDR-1:0] m0_address,
    input  logic [WIDTH_BE-1:0]   m0_byteenable,
    input  logic [WIDTH_DATA-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [WIDTH_DATA-1:0] m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic                  m1_write,
    input  logic                  m1_read,
    input  logic [WIDTH_ADDR-1:0] m1_address,
    input  logic [WIDTH_BE-1:0]   m1_byteenable,
    input  logic [WIDTH_DATA-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [WIDTH_DATA-1:0] m1_readdata,
    output logic                  m1_readdatavalid,
    output logic                  avl_chipselect_dsp,
    output logic                  avl_write_dsp,
    output logic [WIDTH_ADDR-1:0] avl_address_dsp,
    output logic [WIDTH_BE-1:0]   avl_byteenable_dsp,
    output logic [WIDTH_DATA-1:0] avl_writedata_dsp,
    input  logic [WIDTH_DATA-1:0] avl_readdata_dsp
);

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    req_id_t               gnt_q, gnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [1:0]            wait_q, wait_d;
    logic [1:0]            rdv_q, rdv_d;
    logic [WIDTH_DATA-1:0] rdata0_q, rdata0_d;
    logic [WIDTH_DATA-1:0] rdata1_q, rdata1_d;
    logic                  cs_q, cs_d;
    logic                  write_q, write_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_BE-1:0]   be_q, be_d;
    logic [WIDTH_DATA-1:0] wdata_q, wdata_d;

    logic [1:0] req;
    logic       take;
    req_id_t    grant;

    assign req  = {m1_write | m1_read, m0_write | m0_read};
    assign take = (state_q == ST_IDLE) && (req != 2'b00);

    rr_arbiter_2 u_rr (
        .clk    (clk_dsp),
        .rst_n  (reset_n),
        .req    (req),
        .update (take),
        .grant  (grant)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        is_wr_d  = is_wr_q;
        wait_d   = '1;
        rdv_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cs_d     = 1'b0;
        write_d  = 1'b0;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d       = ST_ISSUE;
                    gnt_d         = grant;
                    cs_d          = 1'b1;
                    wait_d[grant] = 1'b0;
                    if (grant == 1'b0) begin
                        is_wr_d = m0_write;
                        addr_d  = m0_address;
                        be_d    = m0_byteenable;
                        wdata_d = m0_writedata;
                    end else begin
                        is_wr_d = m1_write;
                        addr_d  = m1_address;
                        be_d    = m1_byteenable;
                        wdata_d = m1_writedata;
                    end
                    write_d = is_wr_d;
                end
            end
            ST_ISSUE: begin
                if (is_wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                end
            end
            // Count 0 marks the cycle in which the register file drives valid data.
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_RD_RESP;
                    rdv_d[gnt_q] = 1'b1;
                    if (gnt_q == 1'b0) begin
                        rdata0_d = avl_readdata_dsp;
                    end else begin
                        rdata1_d = avl_readdata_dsp;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_dsp or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            is_wr_q  <= 1'b0;
            wait_q   <= '1;
            rdv_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cs_q     <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            is_wr_q  <= is_wr_d;
            wait_q   <= wait_d;
            rdv_q    <= rdv_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cs_q     <= cs_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    assign m0_waitrequest     = wait_q[0];
    assign m1_waitrequest     = wait_q[1];
    assign m0_readdatavalid   = rdv_q[0];
    assign m1_readdatavalid   = rdv_q[1];
    assign m0_readdata        = rdata0_q;
    assign m1_readdata        = rdata1_q;
    assign avl_chipselect_dsp = cs_q;
    assign avl_write_dsp      = write_q;
    assign avl_address_dsp    = addr_q;
    assign avl_byteenable_dsp = be_q;
    assign avl_writedata_dsp  = wdata_q;

endmodule
